// File: rtl/semiauto_nav.sv
// Semi-automatic line-following navigator: drives forward until a crossroad, waits for a
// driver button, then runs a timed turn and a cooldown before resuming forward motion.
`timescale 1ns/1ps

module semiauto_nav #(
    parameter int DET_W        = 4,
    parameter int TICK_DIV     = 2000000,
    parameter int TURN_TICKS   = 200,
    parameter int AROUND_TICKS = 400,
    parameter int COOL_TICKS   = 50,
    parameter int CNT_W        = 11
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             power,
    input  logic [1:0]       global_state,
    input  logic [DET_W-1:0] detector,
    input  logic             straight,
    input  logic             left,
    input  logic             right,
    input  logic             back,
    output logic [1:0]       nav_state,
    output logic [3:0]       moving_state,
    output logic             cmd_ack
);

    typedef enum logic [1:0] {
        NAV_FORWARD = 2'b00,
        NAV_WAIT    = 2'b01,
        NAV_TURN    = 2'b10,
        NAV_COOL    = 2'b11
    } nav_e;

    typedef enum logic [3:0] {
        MOV_STOP    = 4'b0000,
        MOV_FORWARD = 4'b0001,
        MOV_LEFT    = 4'b0100,
        MOV_RIGHT   = 4'b1000
    } mov_e;

    localparam int MAX_LIM = (TURN_TICKS > AROUND_TICKS)
                           ? ((TURN_TICKS > COOL_TICKS) ? TURN_TICKS : COOL_TICKS)
                           : ((AROUND_TICKS > COOL_TICKS) ? AROUND_TICKS : COOL_TICKS);

    generate
        if (DET_W < 3 || TICK_DIV < 1 || TURN_TICKS < 1 || AROUND_TICKS < 1 || COOL_TICKS < 1
            || CNT_W < 1 || (CNT_W < 31 && (32'sd1 << CNT_W) <= MAX_LIM)) begin : g_bad_params
            $error("semiauto_nav: illegal parameter combination");
        end
    endgenerate

    localparam int                 PRE_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   TURN_LAST   = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0]   AROUND_LAST = CNT_W'(AROUND_TICKS - 1);
    localparam logic [CNT_W-1:0]   COOL_LAST   = CNT_W'(COOL_TICKS - 1);

    // Button vector order: [0]=straight, [1]=left, [2]=right, [3]=back.
    logic [DET_W-1:0] det_s1_q, det_s2_q;
    logic [3:0]       btn_s1_q, btn_s2_q, btn_hist_q;
    logic [2:0]       arm_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;
    nav_e             nav_q, nav_d;
    mov_e             mov_q, mov_d;
    logic             ack_q, ack_d;

    logic       tick;
    logic       crossroad;
    logic       enable;
    logic [3:0] btn_ev;
    logic       unused_det;

    assign tick       = (pre_q == PRE_LAST);
    assign crossroad  = det_s2_q[0] | ~det_s2_q[1] | ~det_s2_q[2];
    assign unused_det = ^det_s2_q;
    assign enable     = power & ((global_state == 2'b01) | (global_state == 2'b10));

    // Edges are only trusted once the history flop holds a post-reset sample, so a button
    // held through reset release is seen as already pressed rather than as a new press.
    assign btn_ev = arm_q[2] ? (btn_s2_q & ~btn_hist_q) : 4'b0000;

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nav_d  = nav_q;
        mov_d  = mov_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        ack_d  = 1'b0;

        if (!enable) begin
            nav_d = NAV_WAIT;
            mov_d = MOV_STOP;
            cnt_d = '0;
        end else begin
            case (nav_q)
                NAV_FORWARD: begin
                    if (crossroad) begin
                        nav_d = NAV_WAIT;
                        mov_d = MOV_STOP;
                    end else begin
                        mov_d = MOV_FORWARD;
                    end
                end
                NAV_WAIT: begin
                    mov_d = MOV_STOP;
                    cnt_d = '0;
                    if (btn_ev[0]) begin
                        nav_d = NAV_COOL;
                        mov_d = MOV_FORWARD;
                        ack_d = 1'b1;
                    end else if (btn_ev[1]) begin
                        nav_d  = NAV_TURN;
                        mov_d  = MOV_LEFT;
                        last_d = TURN_LAST;
                        ack_d  = 1'b1;
                    end else if (btn_ev[2]) begin
                        nav_d  = NAV_TURN;
                        mov_d  = MOV_RIGHT;
                        last_d = TURN_LAST;
                        ack_d  = 1'b1;
                    end else if (btn_ev[3]) begin
                        nav_d  = NAV_TURN;
                        mov_d  = MOV_RIGHT;
                        last_d = AROUND_LAST;
                        ack_d  = 1'b1;
                    end
                end
                NAV_TURN: begin
                    if (tick) begin
                        if (cnt_q == last_q) begin
                            nav_d = NAV_COOL;
                            mov_d = MOV_FORWARD;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                NAV_COOL: begin
                    mov_d = MOV_FORWARD;
                    if (tick) begin
                        if (cnt_q == COOL_LAST) begin
                            nav_d = NAV_FORWARD;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    nav_d = NAV_WAIT;
                    mov_d = MOV_STOP;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            det_s1_q   <= '0;
            det_s2_q   <= '0;
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_hist_q <= '0;
            arm_q      <= '0;
            pre_q      <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            nav_q      <= NAV_WAIT;
            mov_q      <= MOV_STOP;
            ack_q      <= 1'b0;
        end else begin
            det_s1_q   <= detector;
            det_s2_q   <= det_s1_q;
            btn_s1_q   <= {back, right, left, straight};
            btn_s2_q   <= btn_s1_q;
            btn_hist_q <= btn_s2_q;
            arm_q      <= {arm_q[1:0], 1'b1};
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            nav_q      <= nav_d;
            mov_q      <= mov_d;
            ack_q      <= ack_d;
        end
    end

    assign nav_state    = nav_q;
    assign moving_state = mov_q;
    assign cmd_ack      = ack_q;

endmodule

// File: tb/tb_semiauto_nav.sv
// Directed bench for semiauto_nav with a fast prescaler: turns, cooldown, crossroad,
// enable override and reset behaviour, all against hand-derived expectations.
`timescale 1ns/1ps

module tb_semiauto_nav;

    localparam int DET_W = 4;

    localparam logic [1:0] S_FORWARD = 2'b00;
    localparam logic [1:0] S_WAIT    = 2'b01;
    localparam logic [1:0] S_TURN    = 2'b10;
    localparam logic [1:0] S_COOL    = 2'b11;
    localparam logic [3:0] M_STOP    = 4'b0000;
    localparam logic [3:0] M_FWD     = 4'b0001;
    localparam logic [3:0] M_LEFT    = 4'b0100;
    localparam logic [3:0] M_RIGHT   = 4'b1000;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             power;
    logic [1:0]       global_state;
    logic [DET_W-1:0] detector;
    logic             straight, left, right, back;
    logic [1:0]       nav_state;
    logic [3:0]       moving_state;
    logic             cmd_ack;

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    int a0, dur, bad;

    semiauto_nav #(
        .DET_W(DET_W), .TICK_DIV(4), .TURN_TICKS(3), .AROUND_TICKS(6),
        .COOL_TICKS(2), .CNT_W(4)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .power(power), .global_state(global_state),
        .detector(detector), .straight(straight), .left(left), .right(right), .back(back),
        .nav_state(nav_state), .moving_state(moving_state), .cmd_ack(cmd_ack)
    );

    always #5 sys_clk = ~sys_clk;

    // Counts acknowledge pulses, sampled shortly after each rising edge.
    always begin
        @(posedge sys_clk);
        #2;
        if (cmd_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {back, right, left, straight} = b;
    endtask

    // Counts cycles spent in state st (current sample included), tallying samples whose
    // motion code differs from mv; optionally pulses left at cycle pulse_at.
    task automatic measure(input logic [1:0] st, input logic [3:0] mv, input int pulse_at,
                           output int d, output int nbad);
        d    = 1;
        nbad = 0;
        for (int i = 0; i < 80; i++) begin
            if (d == pulse_at) left = 1'b1;
            else if (d == pulse_at + 1) left = 1'b0;
            @(negedge sys_clk);
            if (nav_state !== st) break;
            d++;
            if (moving_state !== mv) nbad++;
        end
        left = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; power = 1'b1; global_state = 2'b01; detector = 4'b0110;
        set_btn(4'b0000);
        #12;
        check("rst_nav", nav_state, S_WAIT);
        check("rst_mov", moving_state, M_STOP);
        check("rst_ack", cmd_ack, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        cyc(6);
        check("idle_nav", nav_state, S_WAIT);
        check("idle_mov", moving_state, M_STOP);

        // Left turn: 3 ticks of TURN, 2 of COOL, then forward.
        a0 = ack_cnt;
        set_btn(4'b0010); cyc(1); set_btn(4'b0000); cyc(1);
        check("left_latency", nav_state, S_WAIT);
        cyc(1);
        check("left_nav", nav_state, S_TURN);
        check("left_mov", moving_state, M_LEFT);
        check("left_ack_pulse", cmd_ack, 1'b1);
        measure(S_TURN, M_LEFT, -5, dur, bad);
        check("left_turn_len_9to12", (dur >= 9 && dur <= 12), 1'b1);
        check("left_turn_mov_held", bad, 0);
        check("left_cool_nav", nav_state, S_COOL);
        check("left_cool_mov", moving_state, M_FWD);
        measure(S_COOL, M_FWD, -5, dur, bad);
        check("left_cool_len_5to8", (dur >= 5 && dur <= 8), 1'b1);
        check("left_fwd_nav", nav_state, S_FORWARD);
        check("left_fwd_mov", moving_state, M_FWD);
        check("left_ack_count", ack_cnt - a0, 1);

        // Crossroad via detector bit 1.
        cyc(3);
        check("fwd_no_xr", nav_state, S_FORWARD);
        detector = 4'b0100;
        cyc(2);
        check("xr_latency", nav_state, S_FORWARD);
        cyc(1);
        check("xr_nav", nav_state, S_WAIT);
        check("xr_mov", moving_state, M_STOP);
        cyc(10);
        check("xr_stays_wait", nav_state, S_WAIT);
        detector = 4'b0110;

        // Straight and back together: straight wins, back is dropped.
        a0 = ack_cnt;
        set_btn(4'b1001); cyc(2);
        check("sb_latency", nav_state, S_WAIT);
        cyc(1);
        check("sb_nav", nav_state, S_COOL);
        check("sb_mov", moving_state, M_FWD);
        set_btn(4'b0000);
        measure(S_COOL, M_FWD, -5, dur, bad);
        check("sb_cool_len_5to8", (dur >= 5 && dur <= 8), 1'b1);
        check("sb_fwd_nav", nav_state, S_FORWARD);
        cyc(8);
        check("sb_fwd_stays", nav_state, S_FORWARD);
        check("sb_ack_count", ack_cnt - a0, 1);

        // Detector bit 3 is ignored; bit 0 alone flags a crossroad.
        detector = 4'b1110;
        cyc(6);
        check("det_bit3_ignored", nav_state, S_FORWARD);
        detector = 4'b0111;
        cyc(3);
        check("det_bit0_xr", nav_state, S_WAIT);
        detector = 4'b0110;

        // Turn-around: 6 ticks, left press mid-turn ignored.
        a0 = ack_cnt;
        set_btn(4'b1000); cyc(1); set_btn(4'b0000); cyc(2);
        check("back_nav", nav_state, S_TURN);
        check("back_mov", moving_state, M_RIGHT);
        measure(S_TURN, M_RIGHT, 5, dur, bad);
        check("back_turn_len_21to24", (dur >= 21 && dur <= 24), 1'b1);
        check("back_turn_mov_held", bad, 0);
        check("back_cool_nav", nav_state, S_COOL);
        check("back_ack_count", ack_cnt - a0, 1);
        measure(S_COOL, M_FWD, -5, dur, bad);
        check("back_fwd_nav", nav_state, S_FORWARD);
        detector = 4'b0100;
        cyc(3);
        check("back_xr_wait", nav_state, S_WAIT);
        detector = 4'b0110;

        // Powered off: press is discarded, not queued.
        power = 1'b0;
        a0 = ack_cnt;
        set_btn(4'b0001); cyc(1); set_btn(4'b0000); cyc(5);
        check("pwr_off_nav", nav_state, S_WAIT);
        power = 1'b1;
        cyc(6);
        check("pwr_on_nav", nav_state, S_WAIT);
        check("pwr_ack_count", ack_cnt - a0, 0);

        // Mode drop mid-turn abandons the manoeuvre.
        a0 = ack_cnt;
        set_btn(4'b0100); cyc(1); set_btn(4'b0000); cyc(2);
        check("right_nav", nav_state, S_TURN);
        check("right_mov", moving_state, M_RIGHT);
        cyc(4);
        global_state = 2'b00;
        cyc(1);
        check("gs00_nav", nav_state, S_WAIT);
        check("gs00_mov", moving_state, M_STOP);
        global_state = 2'b01;
        cyc(30);
        check("gs01_nav", nav_state, S_WAIT);
        check("gs01_mov", moving_state, M_STOP);
        check("gs_ack_count", ack_cnt - a0, 1);

        // Reset mid-cooldown with right held through release.
        global_state = 2'b10;
        a0 = ack_cnt;
        set_btn(4'b0001); cyc(1); set_btn(4'b0000); cyc(2);
        check("gs10_cool_nav", nav_state, S_COOL);
        cyc(2);
        set_btn(4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_nav", nav_state, S_WAIT);
        check("async_rst_mov", moving_state, M_STOP);
        check("async_rst_ack", cmd_ack, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        check("held_btn_nav", nav_state, S_WAIT);
        check("held_btn_mov", moving_state, M_STOP);
        check("held_btn_ack", ack_cnt - a0, 1);
        set_btn(4'b0000); cyc(3);
        set_btn(4'b0100); cyc(1); set_btn(4'b0000); cyc(2);
        check("repress_nav", nav_state, S_TURN);
        check("repress_mov", moving_state, M_RIGHT);
        check("repress_ack", ack_cnt - a0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/semiauto_nav.md
SEMIAUTO_NAV -- requirements
Module: semiauto_nav

Interface
REQ-001 Parameters SHALL be: DET_W (default 4) detector width, min 3; TICK_DIV (default 2000000) sys_clk cycles per tick; TURN_TICKS (default 200) ticks per left/right turn; AROUND_TICKS (default 400) ticks per turn-around; COOL_TICKS (default 50) ticks of cooldown; CNT_W (default 11) tick-counter width.
REQ-002 sys_clk  in  1  sole clock; all flops rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 power  in  1  car powered.
REQ-005 global_state  in  2  mode; block enabled only for 2'b01 or 2'b10.
REQ-006 detector  in  DET_W  line sensors, asynchronous.
REQ-007 straight, left, right, back  in  1 each  driver buttons, asynchronous, active-high.
REQ-008 nav_state  out  2  registered FSM state: FORWARD=00, WAIT=01, TURN=10, COOL=11.
REQ-009 moving_state  out  4  registered motion code: STOP=0000, MOVE_FORWARD=0001, TURN_LEFT=0100, TURN_RIGHT=1000; no other values.
REQ-010 cmd_ack  out  1  one-cycle pulse when a button command is accepted.

Function
REQ-011 detector and the four buttons SHALL each pass a 2-flop synchroniser; all logic uses synchronised values only.
REQ-012 crossroad SHALL equal sync_det[0] | ~sync_det[1] | ~sync_det[2]; bits above 2 ignored.
REQ-013 A button event SHALL be a rising edge of its synchronised value (one-flop history); held buttons give one event.
REQ-014 enable = power & (global_state==01 | global_state==10); while enable=0 the next state SHALL be WAIT/STOP, tick counter cleared, cmd_ack 0, button events discarded; this overrides all transitions.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 free-running, emitting tick for one cycle at wrap; cleared only by reset.
REQ-016 Tick counter SHALL clear on entry to TURN or COOL and increment on each tick while in that state; no wrap inside a state.
REQ-017 FORWARD: crossroad=1 -> WAIT, STOP; else stay, MOVE_FORWARD.
REQ-018 WAIT: priority straight > left > right > back on same-cycle events; straight -> COOL, MOVE_FORWARD; left -> TURN, TURN_LEFT, limit TURN_TICKS; right -> TURN, TURN_RIGHT, limit TURN_TICKS; back -> TURN, TURN_RIGHT, limit AROUND_TICKS; none -> stay, STOP.
REQ-019 cmd_ack SHALL pulse in the same cycle the WAIT-exit transition registers; lower-priority simultaneous events are dropped.
REQ-020 Button events outside WAIT SHALL be discarded, not queued.
REQ-021 TURN: on the tick on which counter==limit-1 -> COOL, MOVE_FORWARD; else hold moving_state; limit latched at WAIT exit.
REQ-022 COOL: on the tick on which counter==COOL_TICKS-1 -> FORWARD, MOVE_FORWARD; crossroad ignored in COOL.
REQ-023 Latency: input change at sampling edge k SHALL first affect nav_state/moving_state at edge k+2 (synchroniser + FSM register).
REQ-024 Elaboration SHALL fail if 2^CNT_W <= max(TURN_TICKS, AROUND_TICKS, COOL_TICKS), any tick limit is 0, TICK_DIV < 1, or DET_W < 3.

Reset
REQ-025 rst_n=0 SHALL immediately force nav_state=WAIT, moving_state=STOP, cmd_ack=0, prescaler, tick counter, synchroniser and edge-history flops to 0.
REQ-026 Reset mid-TURN or mid-COOL SHALL abandon the manoeuvre; after release the block sits in WAIT until a new event.
REQ-027 Buttons held through reset release SHALL not generate an event until released and re-pressed.

Verification (TICK_DIV=4, TURN_TICKS=3, AROUND_TICKS=6, COOL_TICKS=2, CNT_W=4)
REQ-028 Enabled, WAIT, pulse left -> cmd_ack once, TURN/0100 for 3 ticks (12 cycles +/- prescaler phase), COOL/0001 for 2 ticks, then FORWARD/0001.
REQ-029 FORWARD, detector 4'b0110 -> 4'b0100 (bit1 low) -> WAIT/0000 within 2 edges; stays WAIT with no buttons.
REQ-030 WAIT, straight and back rise in same cycle -> COOL/0001, one cmd_ack; back dropped; FORWARD after 2 ticks.
REQ-031 back pressed -> TURN/1000 lasts 6 ticks; left pressed mid-turn -> ignored, no cmd_ack.
REQ-032 Mid-TURN set global_state=00 -> WAIT/0000 at next edges; restore 01 -> remains WAIT/0000.
REQ-033 rst_n low mid-COOL -> outputs WAIT/0000 asynchronously; held right through release -> no turn until re-pressed.
